drive_arbiter: RTL and testbench
================================

// Module: drive_arbiter
// PURPOSE
//  Parametrised drive-command arbiter; next generation of the robot mode FSM. Merges IR remote commands,
//  camera target direction and mic-derived speed into one registered drive command plus a PWM enable.
//  Adds manual/auto modes, an IR-silence watchdog, target-lost search with timeout, and glitch-free speed update.
//  Sits between IR/mic/classifier blocks and motor driver; state exported for HEX display.
// PARAMETERS
//  SPEED_W     2        mic speed width
//  PWM_W       8        PWM counter width (PWM_W > SPEED_W)
//  IR_TIMEOUT  5000000  cycles without ir_valid in MANUAL before drive forced to STOP
//  LOST_CYC    2500000  cycles with orange_detected low in AUTO_TRACK before AUTO_SEARCH
//  SEARCH_CYC  25000000 max cycles in AUTO_SEARCH before IDLE
//  BTN_FWD/BTN_BACK/BTN_LEFT/BTN_RIGHT/BTN_STOP/BTN_AUTO  8'h01..8'h06  IR button codes, in that order
// PORTS
//  clk_50           in   1        system clock
//  rst_n            in   1        synchronous active-low reset
//  ir_valid         in   1        1-cycle pulse: ir_button holds a new code
//  ir_button        in   8        IR button code
//  cam_direction    in   3        0 centre, 1 left, 2 right, other = invalid
//  orange_detected  in   1        target present (level)
//  speed_in         in   SPEED_W  requested speed level
//  drive_cmd        out  3        0 STOP,1 FWD,2 BACK,3 LEFT,4 RIGHT,5 SPIN
//  pwm_out          out  1        motor enable PWM
//  state            out  3        0 IDLE,1 MANUAL,2 AUTO_TRACK,3 AUTO_SEARCH
//  timeout_flag     out  1        high while MANUAL watchdog has expired
// BEHAVIOUR
//  Clock and reset: one clock, clk_50; reset is synchronous and active-low (rst_n), sampled on the clk_50 edge.
//  Reset values: state=IDLE, drive_cmd=STOP, pwm_out=0, timeout_flag=0, all counters 0, speed_lat=0.
//  All outputs are registered; an input that changes state updates drive_cmd on the next edge (1-cycle latency).
//  IR decode applies only when ir_valid=1; codes not matching any BTN_* are ignored.
//  Transitions (priority top-down, IR beats camera on same cycle):
//   any state, BTN_STOP        -> IDLE, drive STOP
//   any state, BTN_FWD/BACK/LEFT/RIGHT -> MANUAL, drive that direction, watchdog cleared
//   IDLE/MANUAL, BTN_AUTO      -> AUTO_TRACK; AUTO states ignore BTN_AUTO
//   MANUAL: watchdog counts cycles since last valid code; at IR_TIMEOUT -> drive STOP, timeout_flag=1,
//     counter saturates; the next movement code clears timeout_flag, resumes. State stays MANUAL.
//   AUTO_TRACK: drive from cam_direction (0 FWD, 1 LEFT, 2 RIGHT, invalid STOP) when orange_detected=1;
//     lost counter increments while orange_detected=0 (drive STOP), clears on 1; reaching LOST_CYC -> AUTO_SEARCH.
//   AUTO_SEARCH: drive SPIN; orange_detected=1 -> AUTO_TRACK (search counter cleared);
//     search counter reaching SEARCH_CYC -> IDLE, drive STOP.
//  Counters are cleared on every state entry; no counter wraps (all saturate or exit).
//  PWM: free-running PWM_W-bit counter wraps 2^PWM_W-1 -> 0. speed_lat <= speed_in only on the wrap cycle.
//   duty = {speed_lat, {(PWM_W-SPEED_W){1'b1}}}; pwm_out = (pwm_cnt <= duty) && (drive_cmd != STOP), registered.
//   speed_lat = max gives 100% duty; speed_lat = 0 gives 2^(PWM_W-SPEED_W) high cycles per period.
//  Reset mid-operation: all of the above reset values take effect on the same edge, including an active PWM period.
// TESTING
//  (bench parameters: PWM_W=4, IR_TIMEOUT=8, LOST_CYC=4, SEARCH_CYC=6)
//  Reset, then ir_valid with 8'h01 -> next cycle state=1, drive_cmd=1; 8 idle cycles -> drive_cmd=0, timeout_flag=1.
//  IDLE, ir 8'h06, orange=1, cam_dir=1 -> state=2, drive_cmd=3; cam_dir=5 -> drive_cmd=0.
//  AUTO_TRACK, orange low 4 cycles -> state=3, drive_cmd=5; 6 more cycles -> state=0, drive_cmd=0.
//  AUTO_SEARCH, orange high, same cycle ir 8'h05 -> state=0 (IR wins), drive_cmd=0.
//  speed_in=2 mid-period -> duty stays old until wrap, then pwm_out high for cnt 0..11 of each 16-cycle period.
//  rst_n=0 during AUTO_TRACK with pwm high -> next edge state=0, drive_cmd=0, pwm_out=0, timeout_flag=0.

Source files
------------

// File: rtl/drive_arbiter_if.sv
// drive_arbiter_if: groups the command inputs and drive outputs of the drive arbiter.
//   master : command source / observer (IR, camera, mic side; drives inputs, reads outputs)
//   slave  : the arbiter itself
// Signals:
//   ir_valid        1        one-cycle pulse, ir_button holds a new code
//   ir_button       8        IR button code
//   cam_direction   3        0 centre, 1 left, 2 right, other invalid
//   orange_detected 1        target present (level)
//   speed_in        SPEED_W  requested speed level
//   drive_cmd       3        0 STOP,1 FWD,2 BACK,3 LEFT,4 RIGHT,5 SPIN
//   pwm_out         1        motor enable PWM
//   state           3        0 IDLE,1 MANUAL,2 AUTO_TRACK,3 AUTO_SEARCH
//   timeout_flag    1        MANUAL watchdog expired
interface drive_arbiter_if #(
    parameter int SPEED_W = 2
) ();
    logic               ir_valid;
    logic [7:0]         ir_button;
    logic [2:0]         cam_direction;
    logic               orange_detected;
    logic [SPEED_W-1:0] speed_in;
    logic [2:0]         drive_cmd;
    logic               pwm_out;
    logic [2:0]         state;
    logic               timeout_flag;

    modport master (
        output ir_valid, ir_button, cam_direction, orange_detected, speed_in,
        input  drive_cmd, pwm_out, state, timeout_flag
    );

    modport slave (
        input  ir_valid, ir_button, cam_direction, orange_detected, speed_in,
        output drive_cmd, pwm_out, state, timeout_flag
    );
endinterface

// File: rtl/drive_arbiter.sv
// drive_arbiter: merges IR remote commands, camera target direction and a
// mic-derived speed level into one registered drive command plus a PWM enable.
// Modes: IDLE, MANUAL (IR driven, with silence watchdog), AUTO_TRACK (camera
// driven, with target-lost timer) and AUTO_SEARCH (spin, with search timeout).
// Ports:
//   clk_50  in  system clock
//   rst_n   in  synchronous active-low reset
//   bus     drive_arbiter_if.slave (command inputs, drive/PWM/state outputs)
module drive_arbiter #(
    parameter int          SPEED_W    = 2,
    parameter int          PWM_W      = 8,
    parameter int          IR_TIMEOUT = 5000000,
    parameter int          LOST_CYC   = 2500000,
    parameter int          SEARCH_CYC = 25000000,
    parameter logic [7:0]  BTN_FWD    = 8'h01,
    parameter logic [7:0]  BTN_BACK   = 8'h02,
    parameter logic [7:0]  BTN_LEFT   = 8'h03,
    parameter logic [7:0]  BTN_RIGHT  = 8'h04,
    parameter logic [7:0]  BTN_STOP   = 8'h05,
    parameter logic [7:0]  BTN_AUTO   = 8'h06
) (
    input  logic           clk_50,
    input  logic           rst_n,
    drive_arbiter_if.slave bus
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_MANUAL = 3'd1;
    localparam logic [2:0] ST_TRACK  = 3'd2;
    localparam logic [2:0] ST_SEARCH = 3'd3;

    localparam logic [2:0] DRV_STOP  = 3'd0;
    localparam logic [2:0] DRV_FWD   = 3'd1;
    localparam logic [2:0] DRV_BACK  = 3'd2;
    localparam logic [2:0] DRV_LEFT  = 3'd3;
    localparam logic [2:0] DRV_RIGHT = 3'd4;
    localparam logic [2:0] DRV_SPIN  = 3'd5;

    // Counter widths sized so the terminal value itself is representable.
    localparam int WD_W = $clog2(IR_TIMEOUT + 1);
    localparam int LC_W = $clog2(LOST_CYC + 1);
    localparam int SC_W = $clog2(SEARCH_CYC + 1);

    localparam logic [WD_W-1:0] WD_MAX = WD_W'(IR_TIMEOUT);
    localparam logic [LC_W-1:0] LC_MAX = LC_W'(LOST_CYC);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(SEARCH_CYC);

    logic [2:0]         state_r,      state_nxt_s;
    logic [2:0]         drive_r,      drive_nxt_s;
    logic               tflag_r,      tflag_nxt_s;
    logic               pwm_r,        pwm_nxt_s;
    logic [WD_W-1:0]    wd_cnt_r,     wd_nxt_s;
    logic [LC_W-1:0]    lost_cnt_r,   lost_nxt_s;
    logic [SC_W-1:0]    search_cnt_r, search_nxt_s;
    logic [PWM_W-1:0]   pwm_cnt_r;
    logic [SPEED_W-1:0] speed_lat_r;
    logic [PWM_W-1:0]   duty_s;

    logic               ir_stop_s;
    logic               ir_move_s;
    logic               ir_auto_s;
    logic [LC_W-1:0]    lost_inc_s;
    logic [SC_W-1:0]    search_inc_s;

    // Camera direction to drive command; anything but a present target with
    // a known direction stops the motors.
    function automatic logic [2:0] cam_to_drive(input logic present, input logic [2:0] dir);
        logic [2:0] d;
        if (present) begin
            case (dir)
                3'd0:    d = DRV_FWD;
                3'd1:    d = DRV_LEFT;
                3'd2:    d = DRV_RIGHT;
                default: d = DRV_STOP;
            endcase
        end else begin
            d = DRV_STOP;
        end
        return d;
    endfunction

    // IR decode: unknown codes fall through as if no code arrived. BTN_AUTO
    // only counts from IDLE/MANUAL; AUTO states treat it as noise.
    assign ir_stop_s = bus.ir_valid && (bus.ir_button == BTN_STOP);
    assign ir_move_s = bus.ir_valid && ((bus.ir_button == BTN_FWD)  || (bus.ir_button == BTN_BACK) ||
                                        (bus.ir_button == BTN_LEFT) || (bus.ir_button == BTN_RIGHT));
    assign ir_auto_s = bus.ir_valid && (bus.ir_button == BTN_AUTO) &&
                       ((state_r == ST_IDLE) || (state_r == ST_MANUAL));

    assign lost_inc_s   = lost_cnt_r + LC_W'(1);
    assign search_inc_s = search_cnt_r + SC_W'(1);
    // Low bits forced to ones: speed 0 still yields a short non-zero pulse,
    // max speed covers the whole period.
    assign duty_s       = {speed_lat_r, {(PWM_W - SPEED_W){1'b1}}};

    // Next-state and counter logic; every state change clears all counters.
    always_comb begin
        state_nxt_s  = state_r;
        wd_nxt_s     = wd_cnt_r;
        lost_nxt_s   = lost_cnt_r;
        search_nxt_s = search_cnt_r;
        if (ir_stop_s || ir_move_s || ir_auto_s) begin
            wd_nxt_s     = '0;
            lost_nxt_s   = '0;
            search_nxt_s = '0;
            if (ir_stop_s) begin
                state_nxt_s = ST_IDLE;
            end else if (ir_move_s) begin
                state_nxt_s = ST_MANUAL;
            end else begin
                state_nxt_s = ST_TRACK;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_MANUAL: begin
                    // Saturate at the timeout so the flag stays asserted.
                    if (wd_cnt_r == WD_MAX) begin
                        wd_nxt_s = wd_cnt_r;
                    end else begin
                        wd_nxt_s = wd_cnt_r + WD_W'(1);
                    end
                end
                ST_TRACK: begin
                    if (bus.orange_detected) begin
                        lost_nxt_s = '0;
                    end else if (lost_inc_s == LC_MAX) begin
                        state_nxt_s = ST_SEARCH;
                        lost_nxt_s  = '0;
                    end else begin
                        lost_nxt_s = lost_inc_s;
                    end
                end
                ST_SEARCH: begin
                    if (bus.orange_detected) begin
                        state_nxt_s  = ST_TRACK;
                        search_nxt_s = '0;
                    end else if (search_inc_s == SC_MAX) begin
                        state_nxt_s  = ST_IDLE;
                        search_nxt_s = '0;
                    end else begin
                        search_nxt_s = search_inc_s;
                    end
                end
                default: begin
                    state_nxt_s  = ST_IDLE;
                    wd_nxt_s     = '0;
                    lost_nxt_s   = '0;
                    search_nxt_s = '0;
                end
            endcase
        end
    end

    // Output logic: next drive command, watchdog flag and PWM enable.
    always_comb begin
        drive_nxt_s = DRV_STOP;
        if (ir_stop_s) begin
            drive_nxt_s = DRV_STOP;
        end else if (ir_move_s) begin
            case (bus.ir_button)
                BTN_FWD:   drive_nxt_s = DRV_FWD;
                BTN_BACK:  drive_nxt_s = DRV_BACK;
                BTN_LEFT:  drive_nxt_s = DRV_LEFT;
                BTN_RIGHT: drive_nxt_s = DRV_RIGHT;
                default:   drive_nxt_s = DRV_STOP;
            endcase
        end else if (ir_auto_s) begin
            drive_nxt_s = cam_to_drive(bus.orange_detected, bus.cam_direction);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    drive_nxt_s = DRV_STOP;
                end
                ST_MANUAL: begin
                    if (wd_nxt_s == WD_MAX) begin
                        drive_nxt_s = DRV_STOP;
                    end else begin
                        drive_nxt_s = drive_r;
                    end
                end
                ST_TRACK: begin
                    if (bus.orange_detected) begin
                        drive_nxt_s = cam_to_drive(1'b1, bus.cam_direction);
                    end else if (state_nxt_s == ST_SEARCH) begin
                        drive_nxt_s = DRV_SPIN;
                    end else begin
                        drive_nxt_s = DRV_STOP;
                    end
                end
                ST_SEARCH: begin
                    if (bus.orange_detected) begin
                        drive_nxt_s = cam_to_drive(1'b1, bus.cam_direction);
                    end else if (state_nxt_s == ST_IDLE) begin
                        drive_nxt_s = DRV_STOP;
                    end else begin
                        drive_nxt_s = DRV_SPIN;
                    end
                end
                default: begin
                    drive_nxt_s = DRV_STOP;
                end
            endcase
        end
        tflag_nxt_s = (state_nxt_s == ST_MANUAL) && (wd_nxt_s == WD_MAX);
        pwm_nxt_s   = (pwm_cnt_r <= duty_s) && (drive_r != DRV_STOP);
    end

    // State, counter and output registers with synchronous active-low reset.
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            drive_r      <= DRV_STOP;
            tflag_r      <= 1'b0;
            pwm_r        <= 1'b0;
            wd_cnt_r     <= '0;
            lost_cnt_r   <= '0;
            search_cnt_r <= '0;
            pwm_cnt_r    <= '0;
            speed_lat_r  <= '0;
        end else begin
            state_r      <= state_nxt_s;
            drive_r      <= drive_nxt_s;
            tflag_r      <= tflag_nxt_s;
            pwm_r        <= pwm_nxt_s;
            wd_cnt_r     <= wd_nxt_s;
            lost_cnt_r   <= lost_nxt_s;
            search_cnt_r <= search_nxt_s;
            pwm_cnt_r    <= pwm_cnt_r + PWM_W'(1);
            // Speed only changes at the period boundary so no pulse is cut short.
            if (pwm_cnt_r == {PWM_W{1'b1}}) begin
                speed_lat_r <= bus.speed_in;
            end else begin
                speed_lat_r <= speed_lat_r;
            end
        end
    end

    assign bus.state        = state_r;
    assign bus.drive_cmd    = drive_r;
    assign bus.timeout_flag = tflag_r;
    assign bus.pwm_out      = pwm_r;
endmodule

// File: tb/tb_drive_arbiter.sv
// tb_drive_arbiter: directed stimulus for drive_arbiter with a timestamp-based
// behavioural model compared on every cycle, plus hand-computed literal checks.
module tb_drive_arbiter;
    localparam int SPEED_W    = 2;
    localparam int PWM_W      = 4;
    localparam int IR_TIMEOUT = 8;
    localparam int LOST_CYC   = 4;
    localparam int SEARCH_CYC = 6;
    localparam int PERIOD     = 16;

    logic clk_50 = 1'b0;
    logic rst_n;
    logic chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    drive_arbiter_if #(.SPEED_W(SPEED_W)) bus ();

    drive_arbiter #(
        .SPEED_W(SPEED_W), .PWM_W(PWM_W), .IR_TIMEOUT(IR_TIMEOUT),
        .LOST_CYC(LOST_CYC), .SEARCH_CYC(SEARCH_CYC)
    ) dut (
        .clk_50 (clk_50),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk_50 = ~clk_50;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    // Model: tracks times of state entry and of last target sighting rather
    // than counters; PWM position is simply edges-since-reset mod period.
    int m_state, m_drive, m_tflag, m_pwm, m_k, m_entry, m_lost_start, m_lat;

    function automatic int cam_drv(input logic org, input logic [2:0] cam);
        if (!org) return 0;
        case (cam)
            3'd0:    return 1;
            3'd1:    return 3;
            3'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk_50) begin
        int btn;
        if (!rst_n) begin
            m_state = 0; m_drive = 0; m_tflag = 0; m_pwm = 0;
            m_k = 0; m_entry = 0; m_lost_start = 0; m_lat = 0;
        end else begin
            m_pwm = ((m_k % PERIOD) <= (m_lat * 4 + 3)) && (m_drive != 0);
            if ((m_k % PERIOD) == PERIOD - 1) m_lat = int'(bus.speed_in);
            m_k++;
            btn = int'(bus.ir_button);
            if (bus.ir_valid && btn == 5) begin
                m_state = 0; m_entry = m_k; m_drive = 0;
            end else if (bus.ir_valid && btn >= 1 && btn <= 4) begin
                m_state = 1; m_entry = m_k; m_drive = btn;
            end else if (bus.ir_valid && btn == 6 && m_state <= 1) begin
                m_state = 2; m_entry = m_k; m_lost_start = m_k;
                m_drive = cam_drv(bus.orange_detected, bus.cam_direction);
            end else begin
                case (m_state)
                    0: m_drive = 0;
                    1: if (m_k - m_entry >= IR_TIMEOUT) m_drive = 0;
                    2: begin
                        if (bus.orange_detected) begin
                            m_lost_start = m_k;
                            m_drive = cam_drv(1'b1, bus.cam_direction);
                        end else if (m_k - m_lost_start >= LOST_CYC) begin
                            m_state = 3; m_entry = m_k; m_drive = 5;
                        end else begin
                            m_drive = 0;
                        end
                    end
                    default: begin
                        if (bus.orange_detected) begin
                            m_state = 2; m_entry = m_k; m_lost_start = m_k;
                            m_drive = cam_drv(1'b1, bus.cam_direction);
                        end else if (m_k - m_entry >= SEARCH_CYC) begin
                            m_state = 0; m_entry = m_k; m_drive = 0;
                        end else begin
                            m_drive = 5;
                        end
                    end
                endcase
            end
            m_tflag = (m_state == 1) && (m_k - m_entry >= IR_TIMEOUT);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_50) begin
        if (chk_en) begin
            check("model_state", int'(bus.state), m_state);
            check("model_drive", int'(bus.drive_cmd), m_drive);
            check("model_tflag", int'(bus.timeout_flag), m_tflag);
            check("model_pwm", int'(bus.pwm_out), m_pwm);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    task automatic send_ir(input logic [7:0] code);
        bus.ir_valid  = 1'b1;
        bus.ir_button = code;
        step(1);
        bus.ir_valid  = 1'b0;
        bus.ir_button = 8'h00;
    endtask

    task automatic expect_sd(input string name, input int st, input int drv);
        check({name, "_state"}, int'(bus.state), st);
        check({name, "_drive"}, int'(bus.drive_cmd), drv);
    endtask

    task automatic count_high(input string name, input int expected);
        int hi;
        hi = 0;
        for (int i = 0; i < PERIOD; i++) begin
            hi += int'(bus.pwm_out);
            step(1);
        end
        check(name, hi, expected);
    endtask

    initial begin
        rst_n               = 1'b0;
        bus.ir_valid        = 1'b0;
        bus.ir_button       = 8'h00;
        bus.cam_direction   = 3'd0;
        bus.orange_detected = 1'b0;
        bus.speed_in        = 2'd0;
        step(3);
        chk_en = 1'b1;
        check("rst_state", int'(bus.state), 0);
        check("rst_drive", int'(bus.drive_cmd), 0);
        check("rst_pwm", int'(bus.pwm_out), 0);
        check("rst_tflag", int'(bus.timeout_flag), 0);
        rst_n = 1'b1;

        // Manual forward, then watchdog expiry and saturation.
        send_ir(8'h01);
        expect_sd("man_fwd", 1, 1);
        step(7);
        check("wd_before_drive", int'(bus.drive_cmd), 1);
        check("wd_before_flag", int'(bus.timeout_flag), 0);
        step(1);
        check("wd_expired_drive", int'(bus.drive_cmd), 0);
        check("wd_expired_flag", int'(bus.timeout_flag), 1);
        step(3);
        check("wd_hold_flag", int'(bus.timeout_flag), 1);
        check("wd_hold_state", int'(bus.state), 1);
        send_ir(8'h04);
        expect_sd("man_resume", 1, 4);
        check("man_resume_flag", int'(bus.timeout_flag), 0);
        send_ir(8'h07);
        expect_sd("unknown_code", 1, 4);
        send_ir(8'h05);
        expect_sd("stop", 0, 0);

        // Auto tracking from camera direction.
        bus.orange_detected = 1'b1;
        bus.cam_direction   = 3'd1;
        send_ir(8'h06);
        expect_sd("auto_left", 2, 3);
        bus.cam_direction = 3'd5;
        step(1);
        expect_sd("auto_invalid", 2, 0);
        bus.cam_direction = 3'd2;
        step(1);
        expect_sd("auto_right", 2, 4);
        bus.cam_direction = 3'd0;
        step(1);
        expect_sd("auto_centre", 2, 1);
        send_ir(8'h06);
        expect_sd("auto_ignores_auto", 2, 1);

        // Target lost -> search -> search timeout.
        bus.orange_detected = 1'b0;
        step(3);
        expect_sd("lost_before", 2, 0);
        step(1);
        expect_sd("lost_to_search", 3, 5);
        step(5);
        expect_sd("search_before", 3, 5);
        step(1);
        expect_sd("search_timeout", 0, 0);

        // Re-acquire during search.
        send_ir(8'h06);
        expect_sd("auto_no_target", 2, 0);
        step(4);
        expect_sd("search_again", 3, 5);
        bus.orange_detected = 1'b1;
        bus.cam_direction   = 3'd1;
        step(1);
        expect_sd("reacquire", 2, 3);

        // IR wins over camera on the same cycle.
        bus.orange_detected = 1'b0;
        step(4);
        expect_sd("search_third", 3, 5);
        bus.orange_detected = 1'b1;
        send_ir(8'h05);
        expect_sd("ir_beats_cam", 0, 0);

        // PWM duty with speed latched at period wrap.
        bus.cam_direction = 3'd0;
        send_ir(8'h06);
        expect_sd("pwm_drive", 2, 1);
        bus.speed_in = 2'd2;
        step(20);
        count_high("pwm_speed2", 12);
        bus.speed_in = 2'd3;
        step(20);
        count_high("pwm_speed3", 16);
        bus.speed_in = 2'd0;
        step(20);
        count_high("pwm_speed0", 4);

        // Reset in the middle of an active PWM period.
        bus.speed_in = 2'd3;
        step(20);
        check("pre_rst_pwm", int'(bus.pwm_out), 1);
        rst_n = 1'b0;
        step(1);
        check("midrst_state", int'(bus.state), 0);
        check("midrst_drive", int'(bus.drive_cmd), 0);
        check("midrst_pwm", int'(bus.pwm_out), 0);
        check("midrst_tflag", int'(bus.timeout_flag), 0);
        rst_n = 1'b1;
        step(5);
        expect_sd("post_rst", 0, 0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
